// File: rtl/nios2_debug_slave_cmd_bridge.sv
// ---------------------------------------------------------------------------
// nios2_debug_slave_cmd_bridge
//
// System-clock side of the Nios II JTAG debug slave. The virtual-JTAG
// update strobes (vs_udr / vs_uir) arrive as asynchronous levels from the
// TCK domain. They are synchronised, and their rising edges are detected.
// On each update-DR the pair {ir_in, sr} is captured into a small
// first-word fall-through queue. The OCI drains that queue through a
// valid/ready handshake.
//
// Handshake (cmd_*): cmd_valid is high whenever the queue holds at least
// one entry. cmd_ir/cmd_data/cmd_action show the head entry and stay
// stable while cmd_valid is high and cmd_ready is low. An entry is consumed
// on the clk edge where cmd_valid && cmd_ready. cmd_ready while empty is
// ignored.
//
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   vs_udr, vs_uir      update-DR / update-IR levels from the TCK domain
//   ir_in               virtual IR value (stable while the strobes are high)
//   sr                  TCK-domain shift register (stable around capture)
//   cmd_valid/ready     queue head handshake
//   cmd_ir, cmd_data    IR and shift-register value of the head command
//   cmd_action          cmd_data[ACTION_BIT]
//   ir_update           one-cycle pulse on a synchronised vs_uir rise
//   ir_latched          ir_in sampled at the last ir_update
//   fifo_level          number of queued commands
//   overflow            sticky flag: an update-DR was dropped (queue full)
//   overflow_clr        synchronous clear of overflow (a new drop wins)
// ---------------------------------------------------------------------------
module nios2_debug_slave_cmd_bridge #(
    parameter int DATA_W      = 38,
    parameter int IR_W        = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ACTION_BIT  = 34
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          vs_udr,
    input  logic                          vs_uir,
    input  logic [IR_W-1:0]               ir_in,
    input  logic [DATA_W-1:0]             sr,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic [IR_W-1:0]               cmd_ir,
    output logic [DATA_W-1:0]             cmd_data,
    output logic                          cmd_action,
    output logic                          ir_update,
    output logic [IR_W-1:0]               ir_latched,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          overflow_clr
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int ENTRY_W = IR_W + DATA_W;
    localparam int ARM_N   = SYNC_STAGES + 1;
    localparam int ARM_W   = $clog2(ARM_N + 1);

    // -----------------------------------------------------------------------
    // Strobe synchronisers and edge history
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] udr_sync;
    logic [SYNC_STAGES-1:0] uir_sync;
    logic                   udr_hist;
    logic                   uir_hist;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            udr_sync <= '0;
            uir_sync <= '0;
            udr_hist <= 1'b0;
            uir_hist <= 1'b0;
        end else begin
            udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
            uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
            udr_hist <= udr_sync[SYNC_STAGES-1];
            uir_hist <= uir_sync[SYNC_STAGES-1];
        end
    end

    // -----------------------------------------------------------------------
    // Arming counter. Edge detection stays off until the synchroniser and
    // the history flop have been filled from live inputs. A strobe that was
    // already high at reset release then looks like a steady level and not
    // like a fresh update.
    // -----------------------------------------------------------------------
    logic [ARM_W-1:0] arm_cnt;
    logic             armed;

    assign armed = (arm_cnt == ARM_W'(ARM_N));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arm_cnt <= '0;
        end else if (!armed) begin
            arm_cnt <= arm_cnt + ARM_W'(1);
        end
    end

    logic udr_rise;
    logic uir_rise;

    assign udr_rise = armed & udr_sync[SYNC_STAGES-1] & ~udr_hist;
    assign uir_rise = armed & uir_sync[SYNC_STAGES-1] & ~uir_hist;

    // -----------------------------------------------------------------------
    // IR update pulse and latched IR
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_update  <= 1'b0;
            ir_latched <= '0;
        end else begin
            ir_update <= uir_rise;
            if (uir_rise) begin
                ir_latched <= ir_in;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Command queue
    // -----------------------------------------------------------------------
    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LVL_W-1:0]   level;
    logic [ENTRY_W-1:0] last_entry;
    logic [ENTRY_W-1:0] head;
    logic               full;
    logic               pop;
    logic               push;
    logic               drop;

    assign full = (level == LVL_W'(FIFO_DEPTH));
    assign pop  = cmd_valid & cmd_ready;
    // When full, a pop on the same edge frees the head slot. The write then
    // lands in that slot while the read pointer moves past it.
    assign push = udr_rise & (~full | pop);
    assign drop = udr_rise & full & ~pop;

    // Storage needs no reset. An entry is only visible after it was written,
    // and the empty queue shows last_entry.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {ir_in, sr};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            last_entry <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + PTR_W'(1);
                last_entry <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Sticky overflow. A drop on the same edge as a clear keeps the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Head presentation. This is fall-through while entries are queued. Once
    // the queue empties, the last popped command is held.
    // -----------------------------------------------------------------------
    assign cmd_valid  = (level != '0);
    assign head       = cmd_valid ? mem[rd_ptr] : last_entry;
    assign cmd_ir     = head[ENTRY_W-1:DATA_W];
    assign cmd_data   = head[DATA_W-1:0];
    assign cmd_action = head[ACTION_BIT];
    assign fifo_level = level;

endmodule

// File: tb/tb_nios2_debug_slave_cmd_bridge.sv
// ---------------------------------------------------------------------------
// Testbench for nios2_debug_slave_cmd_bridge (default parameters).
// Inputs are driven 1 time unit after the rising clk edge. Outputs are
// sampled at that same point.
// ---------------------------------------------------------------------------
module tb_nios2_debug_slave_cmd_bridge;

    logic        clk;
    logic        reset_n;
    logic        vs_udr;
    logic        vs_uir;
    logic [1:0]  ir_in;
    logic [37:0] sr;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_ir;
    logic [37:0] cmd_data;
    logic        cmd_action;
    logic        ir_update;
    logic [1:0]  ir_latched;
    logic [2:0]  fifo_level;
    logic        overflow;
    logic        overflow_clr;

    nios2_debug_slave_cmd_bridge dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .vs_udr       (vs_udr),
        .vs_uir       (vs_uir),
        .ir_in        (ir_in),
        .sr           (sr),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_ir       (cmd_ir),
        .cmd_data     (cmd_data),
        .cmd_action   (cmd_action),
        .ir_update    (ir_update),
        .ir_latched   (ir_latched),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [39:0] exp_q[$];

    typedef struct packed {
        logic [1:0]  ir;
        logic [37:0] data;
        logic [1:0]  exp_ir;
        logic [37:0] exp_data;
        logic        exp_action;
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_valid"},      64'(cmd_valid),  0);
        check({pfx, "_ir"},         64'(cmd_ir),     0);
        check({pfx, "_data"},       64'(cmd_data),   0);
        check({pfx, "_action"},     64'(cmd_action), 0);
        check({pfx, "_ir_update"},  64'(ir_update),  0);
        check({pfx, "_ir_latched"}, 64'(ir_latched), 0);
        check({pfx, "_level"},      64'(fifo_level), 0);
        check({pfx, "_overflow"},   64'(overflow),   0);
    endtask

    // One update-DR pulse: 4 clk high, 3 clk low. sr/ir_in stay stable
    // throughout the pulse.
    task automatic pulse_udr(input logic [1:0] ir, input logic [37:0] data);
        ir_in  = ir;
        sr     = data;
        vs_udr = 1'b1;
        repeat (4) tick();
        vs_udr = 1'b0;
        repeat (3) tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;

        vecs[0] = '{ir: 2'd0, data: 38'h3F_FFFF_FFFF, exp_ir: 2'd0, exp_data: 38'h3F_FFFF_FFFF, exp_action: 1'b1};
        vecs[1] = '{ir: 2'd2, data: 38'h04_0000_0000, exp_ir: 2'd2, exp_data: 38'h04_0000_0000, exp_action: 1'b1};
        vecs[2] = '{ir: 2'd3, data: 38'h00_0000_0001, exp_ir: 2'd3, exp_data: 38'h00_0000_0001, exp_action: 1'b0};
        vecs[3] = '{ir: 2'd1, data: 38'h3B_1234_5678, exp_ir: 2'd1, exp_data: 38'h3B_1234_5678, exp_action: 1'b0};
        vecs[4] = '{ir: 2'd0, data: 38'h14_0000_0000, exp_ir: 2'd0, exp_data: 38'h14_0000_0000, exp_action: 1'b1};

        reset_n      = 1'b0;
        vs_udr       = 1'b1;
        vs_uir       = 1'b0;
        ir_in        = '0;
        sr           = '0;
        cmd_ready    = 1'b0;
        overflow_clr = 1'b0;

        // Reset state, with vs_udr held high through reset.
        repeat (3) tick();
        check_all_zero("reset");
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("held_udr_no_valid", 64'(cmd_valid), 0);
        end
        check("held_udr_level", 64'(fifo_level), 0);
        vs_udr = 1'b0;
        repeat (4) tick();

        // Single command: latency, one-cycle valid, then hold after the pop.
        ir_in     = 2'b01;
        sr        = 38'h2_0000_00AB;
        cmd_ready = 1'b1;
        vs_udr    = 1'b1;
        tick();
        check("lat_edge1_valid", 64'(cmd_valid), 0);
        tick();
        check("lat_edge2_valid", 64'(cmd_valid), 0);
        tick();
        check("lat_edge3_valid", 64'(cmd_valid), 1);
        check("lat_edge3_ir",    64'(cmd_ir), 1);
        check("lat_edge3_data",  64'(cmd_data), 64'h2_0000_00AB);
        check("lat_edge3_action", 64'(cmd_action), 0);
        tick();
        check("lat_edge4_valid", 64'(cmd_valid), 0);
        check("lat_edge4_level", 64'(fifo_level), 0);
        check("lat_hold_data",   64'(cmd_data), 64'h2_0000_00AB);
        repeat (4) tick();
        vs_udr = 1'b0;
        repeat (4) tick();

        // Table-driven single commands.
        for (int i = 0; i < 5; i++) begin
            ir_in  = vecs[i].ir;
            sr     = vecs[i].data;
            vs_udr = 1'b1;
            lat    = 0;
            while (!cmd_valid && lat < 10) begin
                tick();
                lat++;
            end
            check("tbl_latency", 64'(lat), 3);
            check("tbl_ir",      64'(cmd_ir), 64'(vecs[i].exp_ir));
            check("tbl_data",    64'(cmd_data), 64'(vecs[i].exp_data));
            check("tbl_action",  64'(cmd_action), 64'(vecs[i].exp_action));
            tick();
            vs_udr = 1'b0;
            check("tbl_popped", 64'(cmd_valid), 0);
            repeat (4) tick();
        end

        // Overflow: five commands into a four-entry queue with no consumer.
        cmd_ready = 1'b0;
        exp_q.delete();
        for (int i = 1; i <= 5; i++) begin
            pulse_udr(2'(i), 38'(i));
            if (i <= 4) exp_q.push_back({2'(i), 38'(i)});
        end
        check("ovf_level", 64'(fifo_level), 4);
        check("ovf_flag",  64'(overflow), 1);
        check("ovf_head",  64'(cmd_data), 1);

        // A further drop on the same edge as overflow_clr keeps the flag set.
        ir_in  = 2'd2;
        sr     = 38'd6;
        vs_udr = 1'b1;
        tick();
        tick();
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        check("ovf_set_wins", 64'(overflow), 1);
        tick();
        vs_udr = 1'b0;
        repeat (3) tick();

        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", 64'(cmd_valid), 1);
            check("stall_data",  64'(cmd_data), 1);
        end

        cmd_ready = 1'b1;
        while (exp_q.size() != 0) begin
            check("drain_valid", 64'(cmd_valid), 1);
            check("drain_cmd",   64'({cmd_ir, cmd_data}), 64'(exp_q.pop_front()));
            tick();
        end
        check("drain_empty",   64'(cmd_valid), 0);
        check("drain_hold",    64'(cmd_data), 4);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("empty_ready_level", 64'(fifo_level), 0);
        end
        check("ovf_still_set", 64'(overflow), 1);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        check("ovf_cleared", 64'(overflow), 0);

        // Full queue with a pop and a push on the same edge.
        cmd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pulse_udr(2'(i), 38'(16 + i));
            exp_q.push_back({2'(i), 38'(16 + i)});
        end
        check("full_level", 64'(fifo_level), 4);
        ir_in  = 2'b10;
        sr     = 38'h99;
        vs_udr = 1'b1;
        tick();
        tick();
        cmd_ready = 1'b1;
        check("pp_head", 64'({cmd_ir, cmd_data}), 64'(exp_q.pop_front()));
        exp_q.push_back({2'b10, 38'h99});
        tick();
        cmd_ready = 1'b0;
        check("pp_level",    64'(fifo_level), 4);
        check("pp_overflow", 64'(overflow), 0);
        tick();
        vs_udr = 1'b0;
        repeat (3) tick();
        cmd_ready = 1'b1;
        while (exp_q.size() != 0) begin
            check("pp_drain", 64'({cmd_ir, cmd_data}), 64'(exp_q.pop_front()));
            tick();
        end
        check("pp_drain_level", 64'(fifo_level), 0);
        cmd_ready = 1'b0;
        repeat (2) tick();

        // Coincident update-IR and update-DR.
        ir_in  = 2'b11;
        sr     = 38'h1234;
        vs_uir = 1'b1;
        vs_udr = 1'b1;
        tick();
        tick();
        check("uir_early", 64'(ir_update), 0);
        tick();
        check("uir_pulse",   64'(ir_update), 1);
        check("uir_latched", 64'(ir_latched), 3);
        check("uir_valid",   64'(cmd_valid), 1);
        check("uir_cmd_ir",  64'(cmd_ir), 3);
        check("uir_data",    64'(cmd_data), 64'h1234);
        tick();
        check("uir_pulse_end",  64'(ir_update), 0);
        check("uir_latched_e4", 64'(ir_latched), 3);
        vs_udr = 1'b0;
        vs_uir = 1'b0;
        ir_in  = 2'b01;
        repeat (3) tick();
        check("uir_latched_hold", 64'(ir_latched), 3);

        // Asynchronous reset with three queued commands.
        pulse_udr(2'b01, 38'h55);
        pulse_udr(2'b01, 38'h66);
        check("pre_reset_level", 64'(fifo_level), 3);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        repeat (3) tick();
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("post_reset_no_valid", 64'(cmd_valid), 0);
        end
        check("post_reset_level", 64'(fifo_level), 0);

        // Normal operation after reset.
        cmd_ready = 1'b1;
        ir_in     = 2'b10;
        sr        = 38'h04_0000_0001;
        vs_udr    = 1'b1;
        lat       = 0;
        while (!cmd_valid && lat < 10) begin
            tick();
            lat++;
        end
        check("post_reset_latency", 64'(lat), 3);
        check("post_reset_data",    64'(cmd_data), 64'h04_0000_0001);
        check("post_reset_action",  64'(cmd_action), 1);
        tick();
        vs_udr = 1'b0;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
